// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the Booth MAC stage.
package booth_pkg;
    localparam int OPW   = 16;
    localparam int PRODW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_e;
endpackage

// File: rtl/booth_mac_accumulator_if.sv
// Operand-in and result-out handshake bundle of the MAC stage.
interface booth_mac_accumulator_if #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
);
    import booth_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic signed [OPW-1:0]   multiplicand;
    logic signed [OPW-1:0]   multiplier;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_acc;
    logic                    out_sat;
    logic [CNT_W-1:0]        out_count;

    modport master (
        output in_valid, in_last, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, out_acc, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_last, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, out_acc, out_sat, out_count
    );
endinterface

// File: rtl/booth_mac_accumulator_booth_wallace_cla.sv
// Signed 16x16 multiplier: radix-4 Booth recoding, carry-save tree, 4-bit-lookahead final adder.
module booth_wallace_cla
    import booth_pkg::*;
(
    input  logic signed [OPW-1:0]   a_i,
    input  logic signed [OPW-1:0]   b_i,
    output logic signed [PRODW-1:0] p_o
);
    localparam int NPP = OPW / 2;

    logic [PRODW-1:0] pp [NPP];
    logic [PRODW-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    function automatic logic [2*PRODW-1:0] csa(input logic [PRODW-1:0] x,
                                               input logic [PRODW-1:0] y,
                                               input logic [PRODW-1:0] z);
        logic [PRODW-1:0] carry;
        carry = ((x & y) | (x & z) | (y & z)) << 1;
        return {carry, x ^ y ^ z};
    endfunction

    always_comb begin : booth_recode
        logic [PRODW-1:0] a_ext;
        logic [OPW:0]     b_pad;
        logic [2:0]       grp;
        a_ext = {{(PRODW-OPW){a_i[OPW-1]}}, a_i};
        b_pad = {b_i, 1'b0};
        grp   = 3'b000;
        pp    = '{default: '0};
        for (int i = 0; i < NPP; i++) begin
            grp = b_pad[2*i +: 3];
            case (grp)
                3'b001, 3'b010: pp[i] = a_ext << (2*i);
                3'b011:         pp[i] = a_ext << (2*i + 1);
                3'b100:         pp[i] = (-a_ext) << (2*i + 1);
                3'b101, 3'b110: pp[i] = (-a_ext) << (2*i);
                default:        pp[i] = '0;
            endcase
        end
    end

    // 8 -> 6 -> 4 -> 3 -> 2 operand reduction; arithmetic is modulo 2^PRODW
    assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
    assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
    assign {c2, s2} = csa(s0, c0, s1);
    assign {c3, s3} = csa(c1, pp[6], pp[7]);
    assign {c4, s4} = csa(s2, c2, s3);
    assign {c5, s5} = csa(s4, c4, c3);

    always_comb begin : cla
        logic [PRODW-1:0] g, p, sum;
        logic [3:0]       gk, pk, ck;
        logic             cin;
        g   = s5 & c5;
        p   = s5 ^ c5;
        sum = '0;
        gk  = '0;
        pk  = '0;
        ck  = '0;
        cin = 1'b0;
        for (int k = 0; k < PRODW/4; k++) begin
            gk    = g[4*k +: 4];
            pk    = p[4*k +: 4];
            ck[0] = cin;
            ck[1] = gk[0] | (pk[0] & cin);
            ck[2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & cin);
            ck[3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                  | (pk[2] & pk[1] & pk[0] & cin);
            sum[4*k +: 4] = pk ^ ck;
            cin   = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1])
                  | (pk[3] & pk[2] & pk[1] & gk[0]) | ((&pk) & cin);
        end
        p_o = sum;
    end
endmodule

// File: rtl/booth_mac_accumulator.sv
// Streaming signed MAC: operand register stage, Booth product, saturating dot-product accumulator.
//   state | meaning
//   IDLE  | no partial terms, no result pending
//   ACCUM | partial terms held in the accumulator
//   DONE  | result pending on the output (out_valid)
module booth_mac_accumulator
    import booth_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic acc_clear,
    booth_mac_accumulator_if.slave bus
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    mac_state_e state_q, state_d;

    logic flush, stall, accept, advance, handoff, out_valid;

    logic                  v1_q, v1_d, last1_q, last1_d;
    logic signed [OPW-1:0] a1_q, a1_d, b1_q, b1_d;

    logic signed [ACC_W-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
    logic                    sat_q, sat_d, out_sat_q, out_sat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, out_count_q, out_count_d;

    logic signed [PRODW-1:0] prod;
    logic [ACC_W:0]          prod_ext, acc_ext, sum_ext;
    logic [ACC_W-1:0]        clamped;
    logic                    ovf;
    logic [CNT_W-1:0]        cnt_inc;

    assign flush       = rst | acc_clear;
    assign stall       = out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~flush;
    assign accept      = bus.in_valid & bus.in_ready;
    assign advance     = v1_q & ~stall;
    assign handoff     = out_valid & bus.out_ready;

    // Operand stage
    always_comb begin
        v1_d    = v1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        last1_d = last1_q;
        if (accept) begin
            v1_d    = 1'b1;
            a1_d    = bus.multiplicand;
            b1_d    = bus.multiplier;
            last1_d = bus.in_last;
        end else if (!stall) begin
            v1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            last1_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            last1_q <= last1_d;
        end
    end

    booth_wallace_cla u_mul (
        .a_i (a1_q),
        .b_i (b1_q),
        .p_o (prod)
    );

    // One guard bit is enough: |prod| <= 2^30 and ACC_W >= 33
    assign prod_ext = {{(ACC_W+1-PRODW){prod[PRODW-1]}}, prod};
    assign acc_ext  = {acc_q[ACC_W-1], acc_q};
    assign sum_ext  = acc_ext + prod_ext;
    assign ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    assign clamped  = ovf ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX) : sum_ext[ACC_W-1:0];
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        out_acc_d   = out_acc_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        if (advance) begin
            if (last1_q) begin
                out_acc_d   = clamped;
                out_sat_d   = sat_q | ovf;
                out_count_d = cnt_inc;
                acc_d       = '0;
                sat_d       = 1'b0;
                cnt_d       = '0;
            end else begin
                acc_d = clamped;
                sat_d = sat_q | ovf;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            out_acc_q   <= out_acc_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = last1_q ? DONE : ACCUM;
        end else if (state_q == DONE && handoff) begin
            state_d = (cnt_q != '0) ? ACCUM : IDLE;
        end
    end

    // out_valid is a pure decode of DONE, so a pending result and the state cannot disagree
    always_comb begin
        out_valid = 1'b0;
        if (state_q == DONE) out_valid = 1'b1;
    end

    assign bus.out_valid = out_valid;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_count = out_count_q;

    a_hold_while_stalled: assert property (@(posedge clk)
        (!flush && stall) |=> $stable(out_acc_q));
endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: latency, signs, saturation, backpressure, flush.
module tb_booth_mac_accumulator;
    import booth_pkg::*;

    logic clk = 1'b0;
    logic rst, acc_clear, clear33;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    booth_mac_accumulator_if #(.ACC_W(40), .CNT_W(16)) bus ();
    booth_mac_accumulator_if #(.ACC_W(33), .CNT_W(16)) bus33 ();

    booth_mac_accumulator #(.ACC_W(40), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .acc_clear(acc_clear), .bus(bus));

    booth_mac_accumulator #(.ACC_W(33), .CNT_W(16)) dut33 (
        .clk(clk), .rst(rst), .acc_clear(clear33), .bus(bus33));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b, input logic last);
        int n = 0;
        bus.in_valid = 1'b1; bus.multiplicand = a; bus.multiplier = b; bus.in_last = last;
        #1;
        while (!bus.in_ready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic send33(input logic signed [15:0] a, input logic signed [15:0] b, input logic last);
        int n = 0;
        bus33.in_valid = 1'b1; bus33.multiplicand = a; bus33.multiplier = b; bus33.in_last = last;
        #1;
        while (!bus33.in_ready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (bus33.in_ready !== 1'b1) begin errors++; $display("FAIL send33_ready: in_ready=%b required 1", bus33.in_ready); end
        @(negedge clk);
    endtask

    task automatic wait_result();
        int n = 0;
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wait_result: out_valid=%b required 1", bus.out_valid); end
    endtask

    task automatic wait33();
        int n = 0;
        bus33.in_valid = 1'b0;
        while (bus33.out_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (bus33.out_valid !== 1'b1) begin errors++; $display("FAIL wait33: out_valid=%b required 1", bus33.out_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1; acc_clear = 1'b0; clear33 = 1'b0;
        bus.in_valid = 1'b1; bus.multiplicand = 16'sd7; bus.multiplier = 16'sd7; bus.in_last = 1'b1;
        bus.out_ready = 1'b1;
        bus33.in_valid = 1'b0; bus33.multiplicand = '0; bus33.multiplier = '0; bus33.in_last = 1'b0;
        bus33.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.out_acc !== 40'sd0) begin errors++; $display("FAIL rst_out_acc: got %0d required 0", bus.out_acc); end
        checks++; if (bus.out_sat !== 1'b0 || bus.out_count !== 16'd0) begin
            errors++; $display("FAIL rst_sat_count: got %b/%0d required 0/0", bus.out_sat, bus.out_count); end
        checks++; if (bus33.out_valid !== 1'b0 || bus33.out_acc !== 33'd0) begin
            errors++; $display("FAIL rst33: got %b/%0d required 0/0", bus33.out_valid, bus33.out_acc); end
        rst = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b required 1", bus.in_ready); end
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_beat_dropped: out_valid=%b required 0", bus.out_valid); end
    endtask

    task automatic test_single_vector();
        bus.out_ready = 1'b1;
        send(16'sd3, 16'sd2, 1'b0);
        send(16'sd4, 16'sd5, 1'b1);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_early: out_valid=%b required 0 at N+1", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL t1_latency: out_valid=%b required 1 at N+2", bus.out_valid); end
        checks++; if (bus.out_acc !== 40'sd26) begin errors++; $display("FAIL t1_acc: got %0d required 26", bus.out_acc); end
        checks++; if (bus.out_count !== 16'd2 || bus.out_sat !== 1'b0) begin
            errors++; $display("FAIL t1_count_sat: got %0d/%b required 2/0", bus.out_count, bus.out_sat); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_acc !== 40'sd26) begin
            errors++; $display("FAIL t1_handoff: got %b/%0d required 0/26", bus.out_valid, bus.out_acc); end
    endtask

    task automatic test_signs();
        logic signed [39:0] e;
        send(-16'sd3, -16'sd2, 1'b0);
        send(-16'sd3, 16'sd2, 1'b1);
        wait_result();
        checks++; if (bus.out_acc !== 40'sd0 || bus.out_count !== 16'd2) begin
            errors++; $display("FAIL t2_cancel: got %0d/%0d required 0/2", bus.out_acc, bus.out_count); end
        @(negedge clk);
        send(16'sh7FFF, 16'sh7FFF, 1'b1);
        wait_result();
        checks++; if (bus.out_acc !== 40'sh00_3FFF_0001 || bus.out_count !== 16'd1) begin
            errors++; $display("FAIL t2_maxpos: got %h/%0d required 003fff0001/1", bus.out_acc, bus.out_count); end
        @(negedge clk);
        send(-16'sd5, 16'sd7, 1'b1);
        wait_result();
        e = -40'sd35;
        checks++; if (bus.out_acc !== e) begin errors++; $display("FAIL t2_neg: got %0d required %0d", bus.out_acc, e); end
        @(negedge clk);
        send(16'sh8000, 16'sh7FFF, 1'b1);
        wait_result();
        e = -40'sd1073709056;
        checks++; if (bus.out_acc !== e || bus.out_sat !== 1'b0) begin
            errors++; $display("FAIL t2_minxmax: got %0d/%b required %0d/0", bus.out_acc, bus.out_sat, e); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) send33(16'sh8000, 16'sh8000, i == 3);
        wait33();
        checks++; if (bus33.out_acc !== 33'h0_FFFF_FFFF || bus33.out_sat !== 1'b1 || bus33.out_count !== 16'd4) begin
            errors++; $display("FAIL t3_pos_sat: got %h/%b/%0d required 0ffffffff/1/4", bus33.out_acc, bus33.out_sat, bus33.out_count); end
        @(negedge clk);
        send33(16'sd1, 16'sd1, 1'b1);
        wait33();
        checks++; if (bus33.out_acc !== 33'd1 || bus33.out_sat !== 1'b0 || bus33.out_count !== 16'd1) begin
            errors++; $display("FAIL t3_sat_cleared: got %h/%b/%0d required 1/0/1", bus33.out_acc, bus33.out_sat, bus33.out_count); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) send33(16'sh8000, 16'sh8000, 1'b0);
        send33(-16'sd1, 16'sd1, 1'b1);
        wait33();
        checks++; if (bus33.out_acc !== 33'h0_FFFF_FFFE || bus33.out_sat !== 1'b1 || bus33.out_count !== 16'd6) begin
            errors++; $display("FAIL t3_sticky: got %h/%b/%0d required 0fffffffe/1/6", bus33.out_acc, bus33.out_sat, bus33.out_count); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) send33(16'sh8000, 16'sh7FFF, i == 4);
        wait33();
        checks++; if (bus33.out_acc !== 33'h1_0000_0000 || bus33.out_sat !== 1'b1) begin
            errors++; $display("FAIL t3_neg_sat: got %h/%b required 100000000/1", bus33.out_acc, bus33.out_sat); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send(16'sd2, 16'sd3, 1'b1);
        send(16'sd4, 16'sd4, 1'b0);
        bus.in_valid = 1'b1; bus.multiplicand = 16'sd5; bus.multiplier = 16'sd5; bus.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_acc !== 40'sd6) begin
                errors++; $display("FAIL t4_hold[%0d]: ready/valid/acc=%b/%b/%0d required 0/1/6", i, bus.in_ready, bus.out_valid, bus.out_acc); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL t4_release: in_ready=%b required 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_acc !== 40'sd6) begin
            errors++; $display("FAIL t4_taken: valid/acc=%b/%0d required 0/6", bus.out_valid, bus.out_acc); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 40'sd41 || bus.out_count !== 16'd2) begin
            errors++; $display("FAIL t4_second: valid/acc/count=%b/%0d/%0d required 1/41/2", bus.out_valid, bus.out_acc, bus.out_count); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic signed [39:0] exp_q [3];
        exp_q[0] = 40'sd1; exp_q[1] = 40'sd4; exp_q[2] = 40'sd9;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_last = 1'b1;
        bus.multiplicand = 16'sd1; bus.multiplier = 16'sd1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t5_pre: out_valid=%b required 0", bus.out_valid); end
        bus.multiplicand = 16'sd2; bus.multiplier = 16'sd2;
        @(negedge clk);
        bus.multiplicand = 16'sd3; bus.multiplier = 16'sd3;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== exp_q[i] || bus.out_count !== 16'd1) begin
                errors++; $display("FAIL t5_result[%0d]: valid/acc/count=%b/%0d/%0d required 1/%0d/1", i, bus.out_valid, bus.out_acc, bus.out_count, exp_q[i]); end
            if (i == 0) bus.in_valid = 1'b1; else bus.in_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t5_drain: out_valid=%b required 0", bus.out_valid); end
    endtask

    task automatic test_clear();
        send(16'sd7, 16'sd7, 1'b0);
        send(16'sd8, 16'sd8, 1'b0);
        acc_clear = 1'b1;
        bus.in_valid = 1'b1; bus.multiplicand = 16'sd9; bus.multiplier = 16'sd9; bus.in_last = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL t6_clear_ready: got %b required 0", bus.in_ready); end
        @(negedge clk);
        acc_clear = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_acc !== 40'sd0 || bus.out_count !== 16'd0) begin
            errors++; $display("FAIL t6_flushed: valid/acc/count=%b/%0d/%0d required 0/0/0", bus.out_valid, bus.out_acc, bus.out_count); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_dropped_beat: out_valid=%b required 0", bus.out_valid); end
        send(16'sd5, 16'sd5, 1'b1);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t6_no_stale: out_valid=%b required 0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_acc !== 40'sd25 || bus.out_count !== 16'd1 || bus.out_sat !== 1'b0) begin
            errors++; $display("FAIL t6_result: valid/acc/count/sat=%b/%0d/%0d/%b required 1/25/1/0", bus.out_valid, bus.out_acc, bus.out_count, bus.out_sat); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_signs();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
